// File: rtl/wb_ic_pkg.sv
// Shared types and helpers for the wishbone NxN interconnect and its arbiters.
package wb_ic_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_TERR
    } wb_arb_state_e;

    // Id width that never collapses to zero bits for a single-entry space.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_if.sv
// Request/grant and slave-handshake bundle between the interconnect and one slave arbiter.
interface wb_arbiter_rr_if
    import wb_ic_pkg::*;
#(
    parameter int N_MASTERS       = 4,
    parameter int N_MASTERID_BITS = clog2_min1(N_MASTERS)
);
    logic [N_MASTERS-1:0]       req;
    logic                       sstb;
    logic                       sack;
    logic                       serr;
    logic [N_MASTERS-1:0]       gnt;
    logic [N_MASTERID_BITS-1:0] gnt_id;
    logic                       gnt_valid;
    logic                       to_err;

    modport master (
        output req, sstb, sack, serr,
        input  gnt, gnt_id, gnt_valid, to_err
    );

    modport slave (
        input  req, sstb, sack, serr,
        output gnt, gnt_id, gnt_valid, to_err
    );
endinterface

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first set request after last_id, wrapping modulo N.
module wb_rr_pick
    import wb_ic_pkg::*;
#(
    parameter int N       = 4,
    parameter int ID_BITS = clog2_min1(N)
) (
    input  logic [N-1:0]       req,
    input  logic [ID_BITS-1:0] last_id,
    output logic               pick_valid,
    output logic [ID_BITS-1:0] pick_id,
    output logic [N-1:0]       pick_onehot
);

    always_comb begin
        int cand;
        pick_valid  = 1'b0;
        pick_id     = '0;
        pick_onehot = '0;
        cand        = 0;
        // Offset k=1 is the master just after the previous winner, so it ranks highest.
        for (int k = 1; k <= N; k++) begin
            cand = int'(last_id) + k;
            if (cand >= N) cand = cand - N;
            if (!pick_valid && req[cand]) begin
                pick_valid        = 1'b1;
                pick_id           = ID_BITS'(cand);
                pick_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Per-slave round-robin arbiter: grant held for the whole CYC tenure, with a stall watchdog.
module wb_arbiter_rr
    import wb_ic_pkg::*;
#(
    parameter int N_MASTERS       = 4,
    parameter int N_MASTERID_BITS = clog2_min1(N_MASTERS),
    parameter int TIMEOUT_CYCLES  = 256,
    parameter int TO_CNT_BITS     = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    wb_arbiter_rr_if.slave  bus
);

    localparam int WD_W = (TO_CNT_BITS > 0) ? TO_CNT_BITS : 1;

    wb_arb_state_e              state_q, state_n;
    logic [N_MASTERS-1:0]       gnt_q, gnt_n;
    logic [N_MASTERID_BITS-1:0] gnt_id_q, gnt_id_n;
    logic                       gnt_valid_q, gnt_valid_n;
    logic                       to_err_q, to_err_n;
    logic [N_MASTERID_BITS-1:0] last_id_q, last_id_n;
    logic [WD_W-1:0]            wdog_q, wdog_n;

    logic                       pick_valid;
    logic [N_MASTERID_BITS-1:0] pick_id;
    logic [N_MASTERS-1:0]       pick_onehot;
    logic                       holder_req;
    logic                       stall;

    wb_rr_pick #(.N(N_MASTERS), .ID_BITS(N_MASTERID_BITS)) u_pick (
        .req         (bus.req),
        .last_id     (last_id_q),
        .pick_valid  (pick_valid),
        .pick_id     (pick_id),
        .pick_onehot (pick_onehot)
    );

    assign holder_req = bus.req[gnt_id_q];
    assign stall      = bus.sstb & ~bus.sack & ~bus.serr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            to_err_q    <= 1'b0;
            last_id_q   <= N_MASTERID_BITS'(N_MASTERS - 1);
            wdog_q      <= '0;
        end else begin
            state_q     <= state_n;
            gnt_q       <= gnt_n;
            gnt_id_q    <= gnt_id_n;
            gnt_valid_q <= gnt_valid_n;
            to_err_q    <= to_err_n;
            last_id_q   <= last_id_n;
            wdog_q      <= wdog_n;
        end
    end

    // Release always beats watchdog expiry, and a slave response beats it too.
    always_comb begin
        state_n     = state_q;
        gnt_n       = gnt_q;
        gnt_id_n    = gnt_id_q;
        gnt_valid_n = gnt_valid_q;
        to_err_n    = 1'b0;
        last_id_n   = last_id_q;
        wdog_n      = wdog_q;
        unique case (state_q)
            ARB_IDLE: begin
                wdog_n = '0;
                if (pick_valid) begin
                    gnt_n       = pick_onehot;
                    gnt_id_n    = pick_id;
                    gnt_valid_n = 1'b1;
                    last_id_n   = pick_id;
                    state_n     = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (!holder_req) begin
                    gnt_n       = '0;
                    gnt_valid_n = 1'b0;
                    wdog_n      = '0;
                    state_n     = ARB_IDLE;
                end else if (TIMEOUT_CYCLES == 0 || !stall) begin
                    wdog_n = '0;
                end else if (int'(wdog_q) == TIMEOUT_CYCLES - 1) begin
                    to_err_n = 1'b1;
                    wdog_n   = '0;
                    state_n  = ARB_TERR;
                end else begin
                    wdog_n = wdog_q + WD_W'(1);
                end
            end
            ARB_TERR: begin
                wdog_n = '0;
                if (holder_req) begin
                    state_n = ARB_BUSY;
                end else begin
                    gnt_n       = '0;
                    gnt_valid_n = 1'b0;
                    state_n     = ARB_IDLE;
                end
            end
            default: begin
                gnt_n       = '0;
                gnt_valid_n = 1'b0;
                wdog_n      = '0;
                state_n     = ARB_IDLE;
            end
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.to_err    = to_err_q;

endmodule
